// File: rtl/rv32i_id_hazard_stage.sv
// RV32I decode stage: operand forwarding, branch/jump resolution, load-use stall,
// post-jump squash and sticky halt, with a registered bundle toward execute.
module rv32i_id_hazard_stage #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned NFWD         = 3,
  parameter int unsigned SQUASH_SLOTS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       iw_in,
  input  logic [XLEN-1:0]   pc_in,
  input  logic              in_valid,
  input  logic [XLEN-1:0]   rs1_data_in,
  input  logic [XLEN-1:0]   rs2_data_in,
  input  logic [NFWD-1:0]   fwd_en,
  input  logic [5*NFWD-1:0] fwd_reg,
  input  logic [XLEN*NFWD-1:0] fwd_data,
  input  logic              ex_is_load,
  input  logic [4:0]        ex_rd,
  output logic [4:0]        rs1_reg,
  output logic [4:0]        rs2_reg,
  output logic              stall_out,
  output logic [31:0]       iw_out,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   rs1_data_out,
  output logic [XLEN-1:0]   rs2_data_out,
  output logic [4:0]        wb_reg,
  output logic              wb_en_out,
  output logic              w_en_out,
  output logic              mem_rd_out,
  output logic              valid_out,
  output logic              jump_en_out,
  output logic [XLEN-1:0]   jump_addr,
  output logic              halted
);

  localparam logic [31:0] NopIw    = 32'h0000_0013;
  localparam logic [6:0]  OpReg    = 7'b0110011;
  localparam logic [6:0]  OpImm    = 7'b0010011;
  localparam logic [6:0]  OpLoad   = 7'b0000011;
  localparam logic [6:0]  OpStore  = 7'b0100011;
  localparam logic [6:0]  OpLui    = 7'b0110111;
  localparam logic [6:0]  OpAuipc  = 7'b0010111;
  localparam logic [6:0]  OpJal    = 7'b1101111;
  localparam logic [6:0]  OpJalr   = 7'b1100111;
  localparam logic [6:0]  OpBranch = 7'b1100011;
  localparam logic [6:0]  OpSystem = 7'b1110011;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd_field;

  assign opcode   = iw_in[6:0];
  assign funct3   = iw_in[14:12];
  assign rd_field = iw_in[11:7];
  assign rs1_reg  = iw_in[19:15];
  assign rs2_reg  = iw_in[24:20];

  // Operand resolution: scan from oldest to youngest so the lowest index wins.
  logic [XLEN-1:0] rs1_val, rs2_val;

  always_comb begin
    rs1_val = rs1_data_in;
    rs2_val = rs2_data_in;
    for (int i = int'(NFWD) - 1; i >= 0; i--) begin
      if (fwd_en[i] && fwd_reg[5*i +: 5] == rs1_reg) rs1_val = fwd_data[XLEN*i +: XLEN];
      if (fwd_en[i] && fwd_reg[5*i +: 5] == rs2_reg) rs2_val = fwd_data[XLEN*i +: XLEN];
    end
    if (rs1_reg == 5'd0) rs1_val = '0;
    if (rs2_reg == 5'd0) rs2_val = '0;
  end

  // Decode of control flags and register usage.
  logic dec_wb_en, dec_w_en, dec_mem_rd, use_rs1, use_rs2, is_system;

  always_comb begin
    dec_wb_en  = 1'b0;
    dec_w_en   = 1'b0;
    dec_mem_rd = 1'b0;
    case (opcode)
      OpReg, OpImm, OpLui, OpAuipc, OpJal, OpJalr: dec_wb_en = 1'b1;
      OpLoad: begin
        dec_wb_en  = 1'b1;
        dec_mem_rd = 1'b1;
      end
      OpStore: dec_w_en = 1'b1;
      default: ;
    endcase
  end

  assign use_rs1   = !(opcode == OpLui || opcode == OpAuipc || opcode == OpJal);
  assign use_rs2   = (opcode == OpReg) || (opcode == OpStore) || (opcode == OpBranch);
  assign is_system = (opcode == OpSystem);

  // Branch and jump resolution.
  logic [XLEN-1:0] imm_i, imm_b, imm_j, jalr_sum;
  logic            br_taken, jump_cond;
  logic [XLEN-1:0] target;

  assign imm_i    = {{(XLEN-12){iw_in[31]}}, iw_in[31:20]};
  assign imm_b    = {{(XLEN-13){iw_in[31]}}, iw_in[31], iw_in[7], iw_in[30:25], iw_in[11:8], 1'b0};
  assign imm_j    = {{(XLEN-21){iw_in[31]}}, iw_in[31], iw_in[19:12], iw_in[20], iw_in[30:21],
                     1'b0};
  assign jalr_sum = rs1_val + imm_i;

  always_comb begin
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val < rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    jump_cond = 1'b0;
    target    = '0;
    case (opcode)
      OpJal: begin
        jump_cond = 1'b1;
        target    = pc_in + imm_j;
      end
      OpJalr: begin
        jump_cond = 1'b1;
        target    = {jalr_sum[XLEN-1:1], 1'b0};
      end
      OpBranch: begin
        jump_cond = br_taken;
        target    = pc_in + imm_b;
      end
      default: ;
    endcase
  end

  // Hazard, squash and redirect.
  logic [1:0] sq_q, sq_d;
  logic       halted_q, halted_d;
  logic       load_use, sq_active;

  assign load_use = in_valid && ex_is_load && (ex_rd != 5'd0) &&
                    ((use_rs1 && ex_rd == rs1_reg) || (use_rs2 && ex_rd == rs2_reg));
  assign sq_active   = (sq_q != 2'd0);
  assign stall_out   = halted_q || load_use;
  assign jump_en_out = in_valid && !stall_out && !sq_active && !halted_q && jump_cond;
  assign jump_addr   = jump_en_out ? target : '0;
  assign halted      = halted_q;

  // Next-state bundle; defaults describe a bubble.
  logic [31:0]     iw_d;
  logic [XLEN-1:0] pc_d, rs1_d, rs2_d;
  logic [4:0]      wb_reg_d;
  logic            wb_en_d, w_en_d, mem_rd_d, valid_d;

  always_comb begin
    iw_d     = NopIw;
    pc_d     = '0;
    rs1_d    = '0;
    rs2_d    = '0;
    wb_reg_d = 5'd0;
    wb_en_d  = 1'b0;
    w_en_d   = 1'b0;
    mem_rd_d = 1'b0;
    valid_d  = 1'b0;
    sq_d     = sq_q;
    halted_d = halted_q;
    if (halted_q || load_use || !in_valid) begin
      // bubble
    end else if (sq_active) begin
      sq_d = sq_q - 2'd1;
    end else if (is_system) begin
      halted_d = 1'b1;
    end else begin
      iw_d     = iw_in;
      pc_d     = pc_in;
      rs1_d    = rs1_val;
      rs2_d    = rs2_val;
      wb_reg_d = rd_field;
      wb_en_d  = dec_wb_en;
      w_en_d   = dec_w_en;
      mem_rd_d = dec_mem_rd;
      valid_d  = 1'b1;
      if (jump_en_out) sq_d = 2'(SQUASH_SLOTS);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iw_out       <= NopIw;
      pc_out       <= '0;
      rs1_data_out <= '0;
      rs2_data_out <= '0;
      wb_reg       <= 5'd0;
      wb_en_out    <= 1'b0;
      w_en_out     <= 1'b0;
      mem_rd_out   <= 1'b0;
      valid_out    <= 1'b0;
      sq_q         <= 2'd0;
      halted_q     <= 1'b0;
    end else begin
      iw_out       <= iw_d;
      pc_out       <= pc_d;
      rs1_data_out <= rs1_d;
      rs2_data_out <= rs2_d;
      wb_reg       <= wb_reg_d;
      wb_en_out    <= wb_en_d;
      w_en_out     <= w_en_d;
      mem_rd_out   <= mem_rd_d;
      valid_out    <= valid_d;
      sq_q         <= sq_d;
      halted_q     <= halted_d;
    end
  end

endmodule

// File: tb/tb_rv32i_id_hazard_stage.sv
// Directed bench for rv32i_id_hazard_stage with two squash slots.
module tb_rv32i_id_hazard_stage;

  localparam logic [31:0] Nop    = 32'h0000_0013;
  localparam logic [31:0] Add    = 32'h0020_81B3; // add x3,x1,x2
  localparam logic [31:0] AddX0  = 32'h0020_01B3; // add x3,x0,x2
  localparam logic [31:0] Lui    = 32'h0000_81B7; // lui x3, rs1 field = 1
  localparam logic [31:0] Addi   = 32'h0011_0193; // addi x3,x2,1 (rs2 field = 1)
  localparam logic [31:0] Sw     = 32'h0011_2023; // sw x1,0(x2)
  localparam logic [31:0] Lw     = 32'h0001_2183; // lw x3,0(x2)
  localparam logic [31:0] Beq    = 32'h0020_8863; // beq x1,x2,+16
  localparam logic [31:0] Blt    = 32'h0020_C863;
  localparam logic [31:0] Bltu   = 32'h0020_E863;
  localparam logic [31:0] Bf010  = 32'h0020_A863;
  localparam logic [31:0] Jal    = 32'h0080_80EF; // jal x1,+0x8008
  localparam logic [31:0] Jalr   = 32'h0042_80E7; // jalr x1,4(x5)
  localparam logic [31:0] Ebreak = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] iw_in, pc_in, rs1_data_in, rs2_data_in;
  logic        in_valid;
  logic [2:0]  fwd_en;
  logic [14:0] fwd_reg;
  logic [95:0] fwd_data;
  logic        ex_is_load;
  logic [4:0]  ex_rd, rs1_reg, rs2_reg, wb_reg;
  logic        stall_out, wb_en_out, w_en_out, mem_rd_out, valid_out, jump_en_out, halted;
  logic [31:0] iw_out, pc_out, rs1_data_out, rs2_data_out, jump_addr;

  int checks = 0;
  int errors = 0;

  rv32i_id_hazard_stage #(.XLEN(32), .NFWD(3), .SQUASH_SLOTS(2)) dut (
    .clk(clk), .reset(reset), .iw_in(iw_in), .pc_in(pc_in), .in_valid(in_valid),
    .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in), .fwd_en(fwd_en),
    .fwd_reg(fwd_reg), .fwd_data(fwd_data), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .rs1_reg(rs1_reg), .rs2_reg(rs2_reg), .stall_out(stall_out), .iw_out(iw_out),
    .pc_out(pc_out), .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out),
    .wb_reg(wb_reg), .wb_en_out(wb_en_out), .w_en_out(w_en_out), .mem_rd_out(mem_rd_out),
    .valid_out(valid_out), .jump_en_out(jump_en_out), .jump_addr(jump_addr), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] iw, input logic [31:0] pc, input logic v);
    iw_in    = iw;
    pc_in    = pc;
    in_valid = v;
    #1;
  endtask

  // Two valid NOPs after a taken jump must both become bubbles.
  task automatic flush();
    ex_is_load = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(Nop, 32'h0, 1'b1);
      tick();
      check_eq("squash_bubble", {31'd0, valid_out}, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    iw_in = Nop; pc_in = '0; in_valid = 1'b0;
    rs1_data_in = '0; rs2_data_in = '0;
    fwd_en = '0; fwd_reg = '0; fwd_data = '0;
    ex_is_load = 1'b0; ex_rd = '0;
    tick(); tick();
    check_eq("rst_iw", iw_out, Nop);
    check_eq("rst_valid", {31'd0, valid_out}, 32'd0);
    check_eq("rst_halted", {31'd0, halted}, 32'd0);
    check_eq("rst_pc", pc_out, 32'd0);
    check_eq("rst_wb_en", {31'd0, wb_en_out}, 32'd0);
    check_eq("rst_jump_en", {31'd0, jump_en_out}, 32'd0);
    check_eq("rst_jump_addr", jump_addr, 32'd0);
    reset = 1'b0;

    // Forwarding: source 0 wins over source 2 for x1
    rs1_data_in = 32'd100; rs2_data_in = 32'd4;
    fwd_en = 3'b101; fwd_reg = {5'd1, 5'd0, 5'd1}; fwd_data = {32'd9, 32'd0, 32'd5};
    drive(Add, 32'h40, 1'b1);
    check_eq("rs1_reg", {27'd0, rs1_reg}, 32'd1);
    check_eq("fwd_stall", {31'd0, stall_out}, 32'd0);
    tick();
    check_eq("fwd_rs1", rs1_data_out, 32'd5);
    check_eq("fwd_rs2", rs2_data_out, 32'd4);
    check_eq("fwd_wb_en", {31'd0, wb_en_out}, 32'd1);
    check_eq("fwd_wb_reg", {27'd0, wb_reg}, 32'd3);
    check_eq("fwd_pc", pc_out, 32'h40);
    check_eq("fwd_iw", iw_out, Add);

    // x0 reads zero even when forwarded; source 1 beats source 2 for x2
    rs1_data_in = 32'h55;
    fwd_en = 3'b111; fwd_reg = {5'd2, 5'd2, 5'd0}; fwd_data = {32'd22, 32'd11, 32'd7};
    drive(AddX0, 32'h44, 1'b1);
    tick();
    check_eq("x0_rs1", rs1_data_out, 32'd0);
    check_eq("prio_rs2", rs2_data_out, 32'd11);
    fwd_en = '0;

    // Load-use on rs1
    rs1_data_in = 32'd1; rs2_data_in = 32'd2;
    ex_is_load = 1'b1; ex_rd = 5'd1;
    drive(Add, 32'h48, 1'b1);
    check_eq("lu_stall", {31'd0, stall_out}, 32'd1);
    tick();
    check_eq("lu_bubble_valid", {31'd0, valid_out}, 32'd0);
    check_eq("lu_bubble_iw", iw_out, Nop);
    check_eq("lu_bubble_wb_en", {31'd0, wb_en_out}, 32'd0);
    ex_is_load = 1'b0;
    #1;
    check_eq("lu_stall_clear", {31'd0, stall_out}, 32'd0);
    tick();
    check_eq("lu_follow_iw", iw_out, Add);
    check_eq("lu_follow_valid", {31'd0, valid_out}, 32'd1);

    // LUI and ADDI do not use the matching register field
    ex_is_load = 1'b1; ex_rd = 5'd1;
    drive(Lui, 32'h4C, 1'b1);
    check_eq("lui_no_stall", {31'd0, stall_out}, 32'd0);
    tick();
    check_eq("lui_valid", {31'd0, valid_out}, 32'd1);
    drive(Addi, 32'h50, 1'b1);
    check_eq("addi_no_stall", {31'd0, stall_out}, 32'd0);
    tick();
    check_eq("addi_valid", {31'd0, valid_out}, 32'd1);

    // Store hazard on rs2, then store and load flags
    drive(Sw, 32'h54, 1'b1);
    check_eq("sw_stall", {31'd0, stall_out}, 32'd1);
    tick();
    ex_is_load = 1'b0;
    tick();
    check_eq("sw_w_en", {31'd0, w_en_out}, 32'd1);
    check_eq("sw_wb_en", {31'd0, wb_en_out}, 32'd0);
    drive(Lw, 32'h58, 1'b1);
    tick();
    check_eq("lw_mem_rd", {31'd0, mem_rd_out}, 32'd1);
    check_eq("lw_wb_en", {31'd0, wb_en_out}, 32'd1);

    // BEQ taken, then squash two valid slots; invalid input does not consume a slot
    rs1_data_in = 32'd7; rs2_data_in = 32'd7;
    drive(Beq, 32'h100, 1'b1);
    check_eq("beq_jump_en", {31'd0, jump_en_out}, 32'd1);
    check_eq("beq_jump_addr", jump_addr, 32'h110);
    tick();
    check_eq("beq_passes", iw_out, Beq);
    check_eq("beq_valid", {31'd0, valid_out}, 32'd1);
    drive(Add, 32'h104, 1'b0);
    tick();
    check_eq("sq_invalid", {31'd0, valid_out}, 32'd0);
    drive(Jal, 32'h200, 1'b1);
    check_eq("sq_jal_blocked", {31'd0, jump_en_out}, 32'd0);
    check_eq("sq_jal_addr0", jump_addr, 32'd0);
    tick();
    check_eq("sq_slot1", {31'd0, valid_out}, 32'd0);
    drive(Add, 32'h108, 1'b1);
    tick();
    check_eq("sq_slot2", {31'd0, valid_out}, 32'd0);
    drive(Add, 32'h10C, 1'b1);
    tick();
    check_eq("sq_done", {31'd0, valid_out}, 32'd1);

    // JALR clears bit 0
    rs1_data_in = 32'h203;
    drive(Jalr, 32'h300, 1'b1);
    check_eq("jalr_jump_en", {31'd0, jump_en_out}, 32'd1);
    check_eq("jalr_addr", jump_addr, 32'h206);
    tick();
    check_eq("jalr_wb_en", {31'd0, wb_en_out}, 32'd1);
    check_eq("jalr_wb_reg", {27'd0, wb_reg}, 32'd1);
    flush();

    // Signed vs unsigned compare
    rs1_data_in = 32'hFFFF_FFFF; rs2_data_in = 32'd1;
    drive(Blt, 32'h400, 1'b1);
    check_eq("blt_taken", {31'd0, jump_en_out}, 32'd1);
    check_eq("blt_addr", jump_addr, 32'h410);
    tick();
    flush();
    drive(Bltu, 32'h400, 1'b1);
    check_eq("bltu_not_taken", {31'd0, jump_en_out}, 32'd0);
    check_eq("bltu_addr0", jump_addr, 32'd0);
    tick();
    rs1_data_in = 32'd7; rs2_data_in = 32'd7;
    drive(Bf010, 32'h404, 1'b1);
    check_eq("f3_010_not_taken", {31'd0, jump_en_out}, 32'd0);
    tick();
    check_eq("f3_010_valid", {31'd0, valid_out}, 32'd1);

    // JAL never stalls on a load, even if its immediate aliases the rs1 field
    ex_is_load = 1'b1; ex_rd = 5'd1;
    drive(Jal, 32'h200, 1'b1);
    check_eq("jal_no_stall", {31'd0, stall_out}, 32'd0);
    check_eq("jal_jump_en", {31'd0, jump_en_out}, 32'd1);
    check_eq("jal_addr", jump_addr, 32'h8208);
    tick();
    check_eq("jal_wb_en", {31'd0, wb_en_out}, 32'd1);
    flush();

    // Stalled jump fires once the stall clears
    ex_is_load = 1'b1; ex_rd = 5'd5; rs1_data_in = 32'h203;
    drive(Jalr, 32'h300, 1'b1);
    check_eq("stj_stall", {31'd0, stall_out}, 32'd1);
    check_eq("stj_no_jump", {31'd0, jump_en_out}, 32'd0);
    check_eq("stj_addr0", jump_addr, 32'd0);
    tick();
    check_eq("stj_bubble", {31'd0, valid_out}, 32'd0);
    ex_is_load = 1'b0;
    #1;
    check_eq("stj_fires", {31'd0, jump_en_out}, 32'd1);
    check_eq("stj_addr", jump_addr, 32'h206);
    tick();
    check_eq("stj_passes", iw_out, Jalr);

    // Reset during squash clears the counter
    reset = 1'b1;
    drive(Nop, 32'h0, 1'b0);
    tick();
    reset = 1'b0;
    drive(Add, 32'h60, 1'b1);
    tick();
    check_eq("rst_sq_clear", {31'd0, valid_out}, 32'd1);

    // Halt is sticky until reset
    drive(Ebreak, 32'h500, 1'b1);
    check_eq("ebreak_no_stall", {31'd0, stall_out}, 32'd0);
    tick();
    check_eq("halt_set", {31'd0, halted}, 32'd1);
    check_eq("halt_bubble", iw_out, Nop);
    check_eq("halt_bubble_valid", {31'd0, valid_out}, 32'd0);
    drive(Jal, 32'h504, 1'b1);
    check_eq("halt_stall", {31'd0, stall_out}, 32'd1);
    check_eq("halt_no_jump", {31'd0, jump_en_out}, 32'd0);
    tick();
    check_eq("halt_iw", iw_out, Nop);
    drive(Add, 32'h508, 1'b1);
    tick();
    check_eq("halt_sticky", {31'd0, halted}, 32'd1);
    check_eq("halt_iw2", iw_out, Nop);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("halt_cleared", {31'd0, halted}, 32'd0);
    drive(Add, 32'h600, 1'b1);
    check_eq("post_halt_stall", {31'd0, stall_out}, 32'd0);
    tick();
    check_eq("post_halt_valid", {31'd0, valid_out}, 32'd1);
    check_eq("post_halt_iw", iw_out, Add);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
